// File: rtl/exe_stage_if.sv
// exe_stage_if
// Bundles the execute stage's pipeline handshake and bus signals together with
// its data-SRAM request port.
//   master : the execute stage. It receives ms_allowin, ds_to_es_valid and
//            ds_to_es_bus. It drives es_allowin, es_to_ms_valid/bus,
//            es_to_ds_bus and data_sram_en/wen/addr/wdata.
//   slave  : the surrounding pipeline or environment, with the opposite
//            directions.
interface exe_stage_if #(
  parameter int DS_TO_ES_BUS_WD = 140,
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int ES_TO_DS_BUS_WD = 40
);
  logic                       ms_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus;
  logic                       data_sram_en;
  logic [3:0]                 data_sram_wen;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;

  modport master (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// exe_stage
// Execute stage of a five-stage MIPS-style pipeline. The stage holds one
// instruction at a time. It contains:
//   - a one-hot 12-function ALU,
//   - a 32-cycle radix-2 restoring divider that writes the HI/LO registers,
//   - the data-SRAM request, issued in the cycle the instruction is handed
//     to the memory stage.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : exe_stage_if.master (handshake, stage buses, data-SRAM request)
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 140,
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int ES_TO_DS_BUS_WD = 40
) (
  input  logic         clk,
  input  logic         reset,
  exe_stage_if.master  bus
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  // Stage register and its valid bit
  logic                       es_valid_q;
  logic [DS_TO_ES_BUS_WD-1:0] es_bus_q;

  // Fields decoded from the stage register
  logic [11:0] es_alu_op;
  logic        es_div_op, es_div_signed, es_mfhi, es_mflo;
  logic        es_src1_is_sa, es_src1_is_pc, es_src2_is_imm, es_src2_is_8;
  logic        es_res_from_mem, es_gr_we, es_mem_we;
  logic [4:0]  es_dest;
  logic [15:0] es_imm;
  logic [31:0] es_rs_value, es_rt_value, es_pc;

  assign es_alu_op       = es_bus_q[139:128];
  assign es_div_op       = es_bus_q[127];
  assign es_div_signed   = es_bus_q[126];
  assign es_mfhi         = es_bus_q[125];
  assign es_mflo         = es_bus_q[124];
  assign es_src1_is_sa   = es_bus_q[123];
  assign es_src1_is_pc   = es_bus_q[122];
  assign es_src2_is_imm  = es_bus_q[121];
  assign es_src2_is_8    = es_bus_q[120];
  assign es_res_from_mem = es_bus_q[119];
  assign es_gr_we        = es_bus_q[118];
  assign es_mem_we       = es_bus_q[117];
  assign es_dest         = es_bus_q[116:112];
  assign es_imm          = es_bus_q[111:96];
  assign es_rs_value     = es_bus_q[95:64];
  assign es_rt_value     = es_bus_q[63:32];
  assign es_pc           = es_bus_q[31:0];

  // Divider and HI/LO state
  div_state_e  div_state_q;
  logic [4:0]  div_cnt_q;
  logic [31:0] div_rem_q, div_quo_q, div_dvsr_q;
  logic        div_q_neg_q, div_r_neg_q, div_by_zero_q;
  logic [31:0] hi_q, lo_q;

  // Handshake
  logic es_ready_go, es_allowin;

  assign es_ready_go        = !es_div_op || (div_state_q == DIV_DONE);
  assign es_allowin         = !es_valid_q || (es_ready_go && bus.ms_allowin);
  assign bus.es_allowin     = es_allowin;
  assign bus.es_to_ms_valid = es_valid_q && es_ready_go;

  // Stage register: it loads on acceptance. The valid bit follows the decode
  // valid whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      es_bus_q   <= '0;
    end else begin
      if (es_allowin) begin
        es_valid_q <= bus.ds_to_es_valid;
      end
      if (bus.ds_to_es_valid && es_allowin) begin
        es_bus_q <= bus.ds_to_es_bus;
      end
    end
  end

  // ALU operands
  logic [31:0] alu_src1, alu_src2;

  assign alu_src1 = es_src1_is_sa ? {27'b0, es_imm[10:6]} :
                    es_src1_is_pc ? es_pc : es_rs_value;
  assign alu_src2 = es_src2_is_imm ? {{16{es_imm[15]}}, es_imm} :
                    es_src2_is_8   ? 32'd8 : es_rt_value;

  logic [31:0] add_res, sub_res, slt_res, sltu_res;
  logic [31:0] sll_res, srl_res, sra_res, lui_res, alu_result;

  assign add_res  = alu_src1 + alu_src2;
  assign sub_res  = alu_src1 - alu_src2;
  assign slt_res  = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
  assign sltu_res = {31'b0, alu_src1 < alu_src2};
  assign sll_res  = alu_src2 << alu_src1[4:0];
  assign srl_res  = alu_src2 >> alu_src1[4:0];
  assign sra_res  = $unsigned($signed(alu_src2) >>> alu_src1[4:0]);
  assign lui_res  = {alu_src2[15:0], 16'b0};

  // The ALU opcode is one-hot, so an AND-OR mux selects the result. An
  // all-zero opcode, which divides use, gives a zero result.
  assign alu_result = ({32{es_alu_op[0]}}  & add_res)
                    | ({32{es_alu_op[1]}}  & sub_res)
                    | ({32{es_alu_op[2]}}  & slt_res)
                    | ({32{es_alu_op[3]}}  & sltu_res)
                    | ({32{es_alu_op[4]}}  & (alu_src1 & alu_src2))
                    | ({32{es_alu_op[5]}}  & ~(alu_src1 | alu_src2))
                    | ({32{es_alu_op[6]}}  & (alu_src1 | alu_src2))
                    | ({32{es_alu_op[7]}}  & (alu_src1 ^ alu_src2))
                    | ({32{es_alu_op[8]}}  & sll_res)
                    | ({32{es_alu_op[9]}}  & srl_res)
                    | ({32{es_alu_op[10]}} & sra_res)
                    | ({32{es_alu_op[11]}} & lui_res);

  logic [31:0] es_result;
  assign es_result = es_mfhi ? hi_q : (es_mflo ? lo_q : alu_result);

  // Divider operand magnitudes, taken when the divide starts
  logic [31:0] dvnd_abs, dvsr_abs;
  assign dvnd_abs = (es_div_signed && es_rs_value[31]) ? (32'd0 - es_rs_value) : es_rs_value;
  assign dvsr_abs = (es_div_signed && es_rt_value[31]) ? (32'd0 - es_rt_value) : es_rt_value;

  // One restoring step. The top quotient bit shifts into the partial
  // remainder. When the divisor fits, the low 32 bits of the difference are
  // exact, because the new remainder is always smaller than the divisor.
  logic [32:0] div_partial;
  logic        div_fits;
  logic [31:0] div_rem_d, div_quo_d;

  assign div_partial = {div_rem_q, div_quo_q[31]};
  assign div_fits    = div_partial >= {1'b0, div_dvsr_q};
  assign div_rem_d   = div_fits ? (div_partial[31:0] - div_dvsr_q) : div_partial[31:0];
  assign div_quo_d   = {div_quo_q[30:0], div_fits};

  // With a zero divisor every step "fits". The remainder then equals the
  // dividend magnitude, so re-applying the dividend sign returns the
  // dividend. Only LO needs the all-ones override.
  logic [31:0] div_quo_fix, div_rem_fix;
  assign div_quo_fix = div_by_zero_q ? 32'hFFFF_FFFF :
                       (div_q_neg_q ? (32'd0 - div_quo_q) : div_quo_q);
  assign div_rem_fix = div_r_neg_q ? (32'd0 - div_rem_q) : div_rem_q;

  // Divider FSM. HI/LO are written only on the DONE->IDLE handoff, so reset
  // in the middle of a divide leaves no partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_state_q   <= DIV_IDLE;
      div_cnt_q     <= 5'd0;
      div_rem_q     <= '0;
      div_quo_q     <= '0;
      div_dvsr_q    <= '0;
      div_q_neg_q   <= 1'b0;
      div_r_neg_q   <= 1'b0;
      div_by_zero_q <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
    end else begin
      case (div_state_q)
        DIV_IDLE: begin
          if (es_valid_q && es_div_op) begin
            div_state_q   <= DIV_BUSY;
            div_cnt_q     <= 5'd0;
            div_rem_q     <= '0;
            div_quo_q     <= dvnd_abs;
            div_dvsr_q    <= dvsr_abs;
            div_q_neg_q   <= es_div_signed && (es_rs_value[31] ^ es_rt_value[31]);
            div_r_neg_q   <= es_div_signed && es_rs_value[31];
            div_by_zero_q <= (es_rt_value == 32'd0);
          end
        end
        DIV_BUSY: begin
          div_rem_q <= div_rem_d;
          div_quo_q <= div_quo_d;
          div_cnt_q <= div_cnt_q + 5'd1;
          if (div_cnt_q == 5'd31) begin
            div_state_q <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (bus.ms_allowin) begin
            div_state_q <= DIV_IDLE;
            lo_q        <= div_quo_fix;
            hi_q        <= div_rem_fix;
          end
        end
        default: div_state_q <= DIV_IDLE;
      endcase
    end
  end

  // Output buses
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_w;
  logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus_w;

  assign es_to_ms_bus_w   = {es_res_from_mem, es_gr_we, es_dest, es_result, es_pc};
  assign es_to_ds_bus_w   = {es_res_from_mem, es_valid_q, es_gr_we, es_dest, es_result};
  assign bus.es_to_ms_bus = es_to_ms_bus_w;
  assign bus.es_to_ds_bus = es_to_ds_bus_w;

  // Data SRAM request. It is gated by the actual handoff, so a stalled load
  // or store issues exactly one request.
  logic sram_en;
  assign sram_en             = es_valid_q && es_ready_go && bus.ms_allowin
                             && (es_res_from_mem || es_mem_we);
  assign bus.data_sram_en    = sram_en;
  assign bus.data_sram_wen   = {4{sram_en && es_mem_we}};
  assign bus.data_sram_addr  = alu_result;
  assign bus.data_sram_wdata = es_rt_value;

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL use these bus widths (name, default, meaning):
- DS_TO_ES_BUS_WD, 140, decode-to-execute bus.
- ES_TO_MS_BUS_WD, 71, execute-to-memory bus.
- ES_TO_DS_BUS_WD, 40, forwarding/hazard bus to decode.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high.
- ms_allowin, in, 1, memory stage can accept.
- es_allowin, out, 1, this stage can accept.
- ds_to_es_valid, in, 1, decode bus valid.
- ds_to_es_bus, in, 140, fields MSB-first: alu_op[11:0] 139:128, div_op 127, div_signed 126, mfhi 125, mflo 124, src1_is_sa 123, src1_is_pc 122, src2_is_imm 121, src2_is_8 120, res_from_mem 119, gr_we 118, mem_we 117, dest 116:112, imm 111:96, rs_value 95:64, rt_value 63:32, pc 31:0.
- es_to_ms_valid, out, 1, result valid to memory stage.
- es_to_ms_bus, out, 71, res_from_mem 70, gr_we 69, dest 68:64, es_result 63:32, pc 31:0.
- es_to_ds_bus, out, 40, res_from_mem 39, es_valid 38, gr_we 37, dest 36:32, es_result 31:0.
- data_sram_en, out, 1, data SRAM access enable.
- data_sram_wen, out, 4, byte write enables.
- data_sram_addr, out, 32, access address.
- data_sram_wdata, out, 32, store data.

Function
REQ-003 The stage register SHALL load ds_to_es_bus when ds_to_es_valid && es_allowin; es_valid SHALL load ds_to_es_valid whenever es_allowin.
REQ-004 es_allowin SHALL be !es_valid || (es_ready_go && ms_allowin); es_to_ms_valid SHALL be es_valid && es_ready_go.
REQ-005 es_ready_go SHALL be 1 for non-divide instructions; for div_op it SHALL be 1 only in divider state DONE.
REQ-006 Operand 1 SHALL be, in priority order: src1_is_sa → {27'b0, imm[10:6]}; src1_is_pc → pc; else rs_value.
REQ-007 Operand 2 SHALL be, in priority order: src2_is_imm → sign-extended imm; src2_is_8 → 32'd8; else rt_value.
REQ-008 alu_op SHALL be one-hot, bit 0..11 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- Shifts use op2 as data and op1[4:0] as amount.
- lui = {op2[15:0], 16'b0}.
- add/sub wrap modulo 2^32; no overflow trap.
REQ-009 es_result SHALL be: HI if mfhi, LO if mflo, else the ALU result.
REQ-010 The data SRAM request SHALL fire exactly once per instruction, in the handoff cycle:
- data_sram_en = es_valid && es_ready_go && ms_allowin && (res_from_mem || mem_we).
- data_sram_wen = {4{data_sram_en && mem_we}}.
- data_sram_addr = ALU result; data_sram_wdata = rt_value.
REQ-011 The divider SHALL be a radix-2 restoring FSM with states IDLE, BUSY, DONE and a 5-bit counter.
REQ-012 IDLE→BUSY SHALL occur when es_valid && div_op; dividend/divisor magnitudes and result signs are latched and the counter is cleared.
REQ-013 BUSY SHALL produce one quotient bit per cycle; after 32 BUSY cycles (counter wraps 31→0) the FSM SHALL enter DONE.
REQ-014 DONE→IDLE SHALL occur when ms_allowin; in that same edge LO←quotient and HI←remainder.
REQ-015 Signed division: quotient is negated when operand signs differ; remainder takes the dividend's sign. Unsigned division uses raw operands.
REQ-016 Divide by zero SHALL complete normally with no exception and no extra latency: LO=0xFFFFFFFF, HI=dividend.
REQ-017 A divide SHALL occupy the stage for 34 cycles (1 IDLE + 32 BUSY + 1 DONE) when ms_allowin is held high; each DONE cycle with ms_allowin=0 adds 1 cycle.
REQ-018 mfhi/mflo SHALL read HI/LO registers combinationally; an mfhi/mflo entering the cycle after a divide's handoff SHALL see the new values.
REQ-019 es_to_ds_bus SHALL reflect the current stage contents every cycle, including while stalled.

Reset
REQ-020 On reset the block SHALL set:
- es_valid=0; divider state=IDLE; counter=0; HI=LO=0; stage register=0.
- Hence es_allowin=1, es_to_ms_valid=0, data_sram_en=0, data_sram_wen=0.
REQ-021 Reset asserted mid-divide SHALL abort the divide to IDLE with HI/LO cleared; no partial result is written.

Verification
REQ-022 addu: rs=0x7FFFFFFF, rt=1, ms_allowin=1 → next cycle es_to_ms_valid=1, es_result=0x80000000, data_sram_en=0.
REQ-023 sw: rs=0x1000, imm=0xFFFC, rt=0xDEADBEEF → data_sram_en=1, wen=4'hF, addr=0x0FFC, wdata=0xDEADBEEF, asserted for exactly one cycle even with ms_allowin low for 3 cycles first.
REQ-024 Signed div: rs=-7, rt=2 → es_allowin=0 for 33 cycles, then handoff; a following mflo returns 0xFFFFFFFD and mfhi returns 0xFFFFFFFF.
REQ-025 Unsigned div by zero: rs=0x12345678, rt=0 → LO=0xFFFFFFFF, HI=0x12345678, latency identical to REQ-017.
REQ-026 Reset pulsed at BUSY count 10 → next cycle state IDLE, es_valid=0, HI=LO=0, es_allowin=1.
